// File: rtl/radar_core_pio_pkg.sv
// Shared definitions for the radar core output PIO slave.
// Combinational constants only; no latency.
// No flow control; constants only.
package radar_core_pio_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE     = 3'd6;
  localparam logic [2:0] ADDR_STATUS    = 3'd7;

  // STATUS register bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_COLL_BIT = 1;

  // Pulse engine states
  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/radar_core_pio_pulse_timer.sv
// Pulse width timer: counts len+1 cycles from start, reloadable and abortable.
// busy rises the cycle after start; done is combinational in the final cycle.
// No backpressure; start/restart/abort are single-cycle commands.
module radar_core_pio_pulse_timer
  import radar_core_pio_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        restart,
  input  logic        abort,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done
);

  pulse_state_e state, state_next;
  logic [15:0]  cnt, cnt_next;

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PULSE_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: abort beats restart, restart beats natural expiry
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      PULSE_IDLE: begin
        if (start) begin
          state_next = PULSE_ACTIVE;
          cnt_next   = len;
        end
      end
      PULSE_ACTIVE: begin
        if (abort) begin
          state_next = PULSE_IDLE;
          cnt_next   = '0;
        end else if (restart) begin
          cnt_next = len;
        end else if (cnt == 16'd0) begin
          state_next = PULSE_IDLE;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
    endcase
  end

  assign busy = (state == PULSE_ACTIVE);
  assign done = busy && (cnt == 16'd0);

endmodule

// File: rtl/radar_core_pio_out_ctrl.sv
// Avalon-MM output PIO with atomic set/clear and an optional timed pulse engine.
// Writes land on out_port the next cycle; readdata is registered, 1-cycle latency.
// No wait states; the slave never stalls the master.
// Pulse engine present only when RADAR_PIO_OUT_PULSE_EN is defined.
module radar_core_pio_out_ctrl
  import radar_core_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0,
  parameter logic [15:0]           PULSE_DEFAULT = 16'd999
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  update_strobe,
  output logic                  pulse_busy
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] out_port_next;
  logic [31:0]           readdata_next;
  logic                  unused_writedata;

  assign wr_en            = chipselect & ~write_n;
  assign wd               = writedata[DATA_WIDTH-1:0];
  assign unused_writedata = ^writedata;

`ifdef RADAR_PIO_OUT_PULSE_EN
  logic [15:0]           pulse_len;
  logic [DATA_WIDTH-1:0] pulse_mask, pulse_mask_next;
  logic                  collision, collision_next;
  logic                  pulse_wr, pulse_start, pulse_restart, pulse_abort, pulse_done;

  // A zero-mask PULSE write is a no-op in every state
  assign pulse_wr      = wr_en && (address == ADDR_PULSE) && (wd != '0);
  assign pulse_start   = pulse_wr & ~pulse_busy;
  assign pulse_restart = pulse_wr & pulse_busy;
  assign pulse_abort   = wr_en && (address == ADDR_DATA) && pulse_busy;

  radar_core_pio_pulse_timer u_pulse_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (pulse_start),
    .restart (pulse_restart),
    .abort   (pulse_abort),
    .len     (pulse_len),
    .busy    (pulse_busy),
    .done    (pulse_done)
  );

  // Mask clears on expiry/abort before new bits merge, so an end-cycle write restarts fresh
  always_comb begin
    pulse_mask_next = pulse_mask;
    collision_next  = collision;
    if (pulse_done || pulse_abort) pulse_mask_next = '0;
    if (pulse_wr) pulse_mask_next = pulse_mask_next | wd;
    if (pulse_restart && !pulse_done) collision_next = 1'b1;
    if (wr_en && (address == ADDR_STATUS) && writedata[STATUS_COLL_BIT]) collision_next = 1'b0;
  end

  // Pulse configuration and tracking registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_len  <= PULSE_DEFAULT;
      pulse_mask <= '0;
      collision  <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_PULSE_LEN)) pulse_len <= writedata[15:0];
      pulse_mask <= pulse_mask_next;
      collision  <= collision_next;
    end
  end
`else
  assign pulse_busy = 1'b0;
`endif

  // Output value: pulse-end clear first, then the CPU write so it wins per bit
  always_comb begin
    out_port_next = out_port;
`ifdef RADAR_PIO_OUT_PULSE_EN
    if (pulse_done) out_port_next = out_port & ~pulse_mask;
`endif
    if (wr_en) begin
      case (address)
        ADDR_DATA:     out_port_next = wd;
        ADDR_OUTSET:   out_port_next = out_port_next | wd;
        ADDR_OUTCLEAR: out_port_next = out_port_next & ~wd;
`ifdef RADAR_PIO_OUT_PULSE_EN
        ADDR_PULSE:    out_port_next = out_port_next | wd;
`endif
        default: ;
      endcase
    end
  end

  // Read mux, zero-extended; write-only and reserved addresses read 0
  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA: readdata_next[DATA_WIDTH-1:0] = out_port;
`ifdef RADAR_PIO_OUT_PULSE_EN
      ADDR_PULSE_LEN: readdata_next[15:0] = pulse_len;
      ADDR_PULSE:     readdata_next[DATA_WIDTH-1:0] = pulse_mask;
      ADDR_STATUS: begin
        readdata_next[STATUS_BUSY_BIT] = pulse_busy;
        readdata_next[STATUS_COLL_BIT] = collision;
      end
`endif
      default: ;
    endcase
  end

  // Output, strobe and read data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port      <= RESET_VALUE;
      update_strobe <= 1'b0;
      readdata      <= '0;
    end else begin
      out_port      <= out_port_next;
      update_strobe <= (out_port_next != out_port);
      readdata      <= readdata_next;
    end
  end

endmodule

// File: tb/tb_radar_core_pio_out_ctrl.sv
// Self-checking bench for radar_core_pio_out_ctrl; read data goes through a scoreboard.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Pulse scenarios run only when RADAR_PIO_OUT_PULSE_EN is defined.
module tb_radar_core_pio_out_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic        update_strobe;
  logic        pulse_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int strobe_cnt = 0;
  int busy_gap = 0;
  logic [31:0] rd_q[$];
  logic rd_vld_d = 1'b0;

  radar_core_pio_out_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .out_port      (out_port),
    .update_strobe (update_strobe),
    .pulse_busy    (pulse_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  // Counts the cycles a bit stays high, bounded so a stuck pulse cannot hang the run
  task automatic measure_high(input int bitn, output int n);
    n = 0;
    while (out_port[bitn] && n < 40) begin
      n++;
      if (pulse_busy !== 1'b1) busy_gap++;
      @(negedge clk);
    end
  endtask

  // A read issued at one rising edge has its data registered by the same edge
  always @(posedge clk) rd_vld_d <= chipselect && write_n;

  // Scoreboard: pop expected read data when the registered response is available
  always @(negedge clk) begin
    if (rd_vld_d) begin
      if (rd_q.size() == 0) check_eq("rd_unexpected", readdata, 32'hDEAD_BEEF);
      else check_eq("rd", readdata, rd_q.pop_front());
    end
  end

  always @(negedge clk) if (update_strobe === 1'b1) strobe_cnt++;

  initial begin : stim
    int s0;
    int n;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_out_port", 32'(out_port), 32'h0);
    check_eq("rst_readdata", readdata, 32'h0);
    check_eq("rst_strobe", 32'(update_strobe), 32'h0);
    check_eq("rst_busy", 32'(pulse_busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Scenario 1: reset register values
    bus_read(3'd0, 32'h0000);
`ifdef RADAR_PIO_OUT_PULSE_EN
    bus_read(3'd1, 32'h03E7);
`else
    bus_read(3'd1, 32'h0000);
`endif

    // Scenario 2: load, set, clear and strobe behaviour
    #1 s0 = strobe_cnt;
    bus_write(3'd0, 32'h00F0);
    check_eq("data_wr", 32'(out_port), 32'h00F0);
    check_eq("strobe_hi", 32'(update_strobe), 32'h1);
    bus_write(3'd4, 32'h0F00);
    check_eq("outset", 32'(out_port), 32'h0FF0);
    bus_write(3'd5, 32'h0030);
    check_eq("outclear", 32'(out_port), 32'h0FC0);
    repeat (2) @(negedge clk);
    #1 check_eq("strobe_cnt3", 32'(strobe_cnt - s0), 32'd3);
    s0 = strobe_cnt;
    bus_write(3'd4, 32'h0F00);
    bus_write(3'd2, 32'hFFFF);
    repeat (2) @(negedge clk);
    #1 check_eq("strobe_none", 32'(strobe_cnt - s0), 32'd0);
    check_eq("reserved_wr", 32'(out_port), 32'h0FC0);
    bus_read(3'd0, 32'h0FC0);
    bus_read(3'd2, 32'h0);
    bus_read(3'd3, 32'h0);
    bus_read(3'd4, 32'h0);
    bus_read(3'd5, 32'h0);

`ifdef RADAR_PIO_OUT_PULSE_EN
    // Scenario 3: single pulse of PULSE_LEN+1 cycles
    bus_write(3'd0, 32'h0000);
    bus_write(3'd1, 32'd4);
    bus_read(3'd1, 32'd4);
    bus_write(3'd6, 32'h0001);
    measure_high(0, n);
    check_eq("pulse_width", 32'(n), 32'd5);
    check_eq("pulse_end_busy", 32'(pulse_busy), 32'h0);
    check_eq("pulse_end_port", 32'(out_port), 32'h0);
    bus_read(3'd7, 32'h0);

    // Scenario 4: second PULSE write at cnt=2 merges, reloads and flags collision
    bus_write(3'd6, 32'h0001);
    @(negedge clk);
    bus_write(3'd6, 32'h0002);
    check_eq("merge_port", 32'(out_port), 32'h0003);
    measure_high(1, n);
    check_eq("merge_width", 32'(n), 32'd5);
    check_eq("merge_end_port", 32'(out_port), 32'h0);
    bus_read(3'd6, 32'h0);
    bus_read(3'd7, 32'h2);
    bus_write(3'd7, 32'h2);
    bus_read(3'd7, 32'h0);
    check_eq("busy_window", 32'(busy_gap), 32'd0);

    // Scenario 5: DATA write aborts a running pulse
    bus_write(3'd6, 32'h0004);
    check_eq("abort_pre_busy", 32'(pulse_busy), 32'h1);
    bus_write(3'd0, 32'h8000);
    check_eq("abort_port", 32'(out_port), 32'h8000);
    check_eq("abort_busy", 32'(pulse_busy), 32'h0);
    bus_read(3'd6, 32'h0);
    bus_read(3'd7, 32'h0);
    bus_write(3'd6, 32'h0010);
    check_eq("pre_rst_port", 32'(out_port), 32'h8010);
`else
    // Scenario 6: pulse registers absent
    bus_write(3'd6, 32'hFFFF);
    check_eq("nopulse_port", 32'(out_port), 32'h0FC0);
    check_eq("nopulse_busy", 32'(pulse_busy), 32'h0);
    bus_write(3'd1, 32'd4);
    bus_read(3'd1, 32'h0);
    bus_read(3'd6, 32'h0);
    bus_read(3'd7, 32'h0);
    check_eq("nopulse_busy2", 32'(pulse_busy), 32'h0);
    bus_write(3'd0, 32'h1234);
    check_eq("pre_rst_port", 32'(out_port), 32'h1234);
`endif

    // Asynchronous reset in the middle of a clock phase
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_port", 32'(out_port), 32'h0);
    check_eq("async_rst_busy", 32'(pulse_busy), 32'h0);
    check_eq("async_rst_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
`ifdef RADAR_PIO_OUT_PULSE_EN
    bus_read(3'd1, 32'h03E7);
    bus_read(3'd6, 32'h0);
`else
    bus_read(3'd1, 32'h0);
`endif
    bus_read(3'd0, 32'h0);

    repeat (3) @(negedge clk);
    #1 check_eq("rd_q_drain", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
